pe_stream_feeder: RTL and testbench

- Parametrised multi-channel bus-side loader for the PE array.
- Replaces bench-driven fmap, weight and psum streaming with synthesizable RTL.
- Each channel reads a programmed burst from a shared single-port local buffer and pushes it into one PE input FIFO.
- Honours per-channel FIFO-full backpressure; round-robin arbitration between channels for the buffer read port.

---
 rtl/pe_stream_feeder.sv | 246 ++++++++++++++++++++++++
 tb/tb_pe_stream_feeder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_stream_feeder.sv
// pe_stream_feeder
//   Multi-channel burst loader for the PE array. Each channel streams a
//   programmed burst from a shared single-port local buffer into its own
//   PE input FIFO. Channels compete round-robin for the buffer read port and
//   stall on per-channel PE FIFO-full.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   start[c]           start pulse; ignored while busy[c]
//   base_addr          per-channel burst start address, channel c at [c*ADDR_WIDTH +: ADDR_WIDTH]
//   burst_len          per-channel word count, channel c at [c*LEN_WIDTH +: LEN_WIDTH]
//   busy[c], done[c]   channel active / one-cycle completion pulse
//   mem_rd_en/addr     buffer read strobe and address (one read per cycle max)
//   mem_rd_data        buffer read data, valid the cycle after mem_rd_en
//   pe_full[c]         PE FIFO full
//   out_data, out_en   per-channel word and write strobe into the PE FIFO
//   stall_cnt          per-channel 16-bit backpressure counters
//
// Build option
//   FEEDER_STALL_CNT_EN  when defined, stall_cnt counts cycles a channel holds
//                        a word but is blocked by pe_full (saturating, cleared
//                        on start accept). When undefined stall_cnt is 0.

// Per-channel engine: burst FSM, address/length counters, 2-entry skid FIFO.
module pe_feeder_ch #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic                  grant,
  input  logic                  ret_vld,
  input  logic [DATA_WIDTH-1:0] ret_data,
  input  logic                  pe_full,
  output logic                  eligible,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  out_en,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [15:0]           stall_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t                 state_q, state_d;
  logic                   done_q, done_d, load;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LEN_WIDTH-1:0]   rem_q;

  logic [1:0][DATA_WIDTH-1:0] mem_q;
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             occ_q, occ_d;
  logic [DATA_WIDTH-1:0]  last_q, out_word;
  logic                   has_word, pop_mem, push_mem;
  logic [2:0]             used;

  // A returning word counts as present this cycle; when the skid is empty it
  // bypasses straight to the PE, which gives the 2-cycle start-to-data latency.
  assign has_word = (occ_q != 2'd0) || ret_vld;
  assign out_en   = has_word && !pe_full;
  assign out_word = (occ_q != 2'd0) ? mem_q[rd_ptr_q] : ret_data;
  assign pop_mem  = out_en && (occ_q != 2'd0);
  assign push_mem = ret_vld && !(out_en && (occ_q == 2'd0));
  assign out_data = out_en ? out_word : last_q;

  always_comb begin
    occ_d = occ_q;
    if (push_mem && !pop_mem)      occ_d = occ_q + 2'd1;
    else if (pop_mem && !push_mem) occ_d = occ_q - 2'd1;
  end

  // Credit = 2 - occupancy - inflight; the in-flight read is the one returning now.
  assign used     = {1'b0, occ_q} + {2'b00, ret_vld};
  assign eligible = (state_q == ST_RUN) && (rem_q != '0) && (used < 3'd2);
  assign rd_addr  = addr_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        load = 1'b1;
        if (burst_len == '0) done_d  = 1'b1;
        else                 state_d = ST_RUN;
      end
      ST_RUN: if (grant && (rem_q == LEN_WIDTH'(1))) state_d = ST_DRAIN;
      // Nothing can be in flight after the RUN->DRAIN grant has returned, so
      // an empty skid after this cycle means the last word has gone out.
      ST_DRAIN: if (occ_d == 2'd0) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (load) begin
        addr_q <= base_addr;
        rem_q  <= burst_len;
      end else if (grant) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);   // wraps mod 2^ADDR_WIDTH
        rem_q  <= rem_q - LEN_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      last_q   <= '0;
    end else begin
      if (push_mem) begin
        mem_q[wr_ptr_q] <= ret_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_mem) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_d;
      if (out_en) last_q <= out_word;
    end
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                           stall_q <= '0;
    else if (load)                                     stall_q <= '0;
    else if (has_word && pe_full && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

module pe_stream_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int NUM_CH     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            start,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] base_addr,
  input  logic [NUM_CH*LEN_WIDTH-1:0]  burst_len,
  output logic [NUM_CH-1:0]            busy,
  output logic [NUM_CH-1:0]            done,
  output logic                         mem_rd_en,
  output logic [ADDR_WIDTH-1:0]        mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rd_data,
  input  logic [NUM_CH-1:0]            pe_full,
  output logic [NUM_CH*DATA_WIDTH-1:0] out_data,
  output logic [NUM_CH-1:0]            out_en,
  output logic [NUM_CH*16-1:0]         stall_cnt
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]                 elig, gnt, ret_vld;
  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] ch_addr;
  logic                              gnt_vld, rd_vld_q;
  logic [CH_W-1:0]                   gnt_id, rr_ptr_q, rd_ch_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign gnt[c]     = gnt_vld && (gnt_id == CH_W'(c));
    assign ret_vld[c] = rd_vld_q && (rd_ch_q == CH_W'(c));

    pe_feeder_ch #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .start     (start[c]),
      .base_addr (base_addr[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .burst_len (burst_len[c*LEN_WIDTH +: LEN_WIDTH]),
      .grant     (gnt[c]),
      .ret_vld   (ret_vld[c]),
      .ret_data  (mem_rd_data),
      .pe_full   (pe_full[c]),
      .eligible  (elig[c]),
      .rd_addr   (ch_addr[c]),
      .busy      (busy[c]),
      .done      (done[c]),
      .out_en    (out_en[c]),
      .out_data  (out_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .stall_cnt (stall_cnt[c*16 +: 16])
    );
  end

  // Round-robin: scan from rr_ptr_q upward (mod NUM_CH), first eligible wins.
  always_comb begin
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      j = int'(rr_ptr_q) + i;
      if (j >= NUM_CH) j = j - NUM_CH;
      if (!gnt_vld && elig[j]) begin
        gnt_vld = 1'b1;
        gnt_id  = CH_W'(j);
      end
    end
  end

  assign mem_rd_en   = gnt_vld;
  assign mem_rd_addr = gnt_vld ? ch_addr[gnt_id] : '0;

  // Registered grant id steers the returning word to its channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      rd_vld_q <= 1'b0;
      rd_ch_q  <= '0;
    end else begin
      rd_vld_q <= gnt_vld;
      rd_ch_q  <= gnt_id;
      if (gnt_vld)
        rr_ptr_q <= (gnt_id == CH_W'(NUM_CH-1)) ? '0 : gnt_id + CH_W'(1);
    end
  end

endmodule

// File: tb/tb_pe_stream_feeder.sv
module tb_pe_stream_feeder;
  localparam int DW = 16, AW = 8, LW = 8, NC = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     start, busy, done, out_en, pe_full;
  logic [NC*AW-1:0]  base_addr;
  logic [NC*LW-1:0]  burst_len;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_rd_addr;
  logic [DW-1:0]     mem_rd_data;
  logic [NC*DW-1:0]  out_data;
  logic [NC*16-1:0]  stall_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;

  pe_stream_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .NUM_CH(NC)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .burst_len(burst_len),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .pe_full(pe_full), .out_data(out_data), .out_en(out_en),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Local buffer model: buffer[i] = i, one-cycle read latency.
  logic [DW-1:0] bmem [256];
  initial for (int i = 0; i < 256; i++) bmem[i] = DW'(i);
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= bmem[mem_rd_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = '0; pe_full = '0; base_addr = '0; burst_len = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    int          ch;
    logic [7:0]  base;
    int          len;
    int          full_lo, full_hi;   // pe_full[ch] high for these relative cycles
    int          nord_lo, nord_hi;   // relative cycles that must see no reads
    logic [15:0] exp_first, exp_last;
    int          exp_first_lat, exp_done_lat;
    logic [15:0] exp_stall;
  } vec_t;

  vec_t vt[5];

  task automatic run_vec(input vec_t v);
    int nw, fl, dl, nd, nrd, nrd_win, bad_other;
    logic busy_seen;
    logic [7:0]  a;
    logic [15:0] lastw;
    logic [NC-1:0] oth;
    nw = 0; fl = -1; dl = -1; nd = 0; nrd = 0; nrd_win = 0; bad_other = 0;
    busy_seen = 1'b0; lastw = '0;
    @(posedge clk); #1;
    start = '0; start[v.ch] = 1'b1; pe_full = '0;
    base_addr[v.ch*AW +: AW] = v.base;
    burst_len[v.ch*LW +: LW] = LW'(v.len);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        start = '0; pe_full = '0;
        if (k >= v.full_lo && k <= v.full_hi) pe_full[v.ch] = 1'b1;
      end
      @(negedge clk);
      if (out_en[v.ch]) begin
        a = v.exp_first[7:0] + 8'(nw);
        lastw = out_data[v.ch*DW +: DW];
        chk("word", 32'(lastw), {24'h0, a});
        if (fl < 0) fl = k;
        nw++;
      end
      oth = out_en; oth[v.ch] = 1'b0;
      if (oth != '0) bad_other++;
      if (done[v.ch]) begin nd++; if (dl < 0) dl = k; end
      if (mem_rd_en) begin
        nrd++;
        if (k >= v.nord_lo && k <= v.nord_hi) nrd_win++;
      end
      if (busy[v.ch]) busy_seen = 1'b1;
    end
    chk("word_count", nw, v.len);
    chk("first_latency", fl, v.exp_first_lat);
    chk("done_latency", dl, v.exp_done_lat);
    chk("done_pulses", nd, 1);
    chk("read_count", nrd, v.len);
    chk("busy_seen", 32'(busy_seen), 32'(v.len != 0));
    chk("other_ch_out_en", bad_other, 0);
    chk("stall_cnt", 32'(stall_cnt[v.ch*16 +: 16]), 32'(v.exp_stall));
    if (v.nord_hi >= v.nord_lo) chk("no_read_while_no_credit", nrd_win, 0);
    if (v.len != 0) begin
      chk("last_word", 32'(lastw), 32'(v.exp_last));
      chk("out_data_hold", 32'(out_data[v.ch*DW +: DW]), 32'(v.exp_last));
    end
  endtask

  initial begin
    int nw, nd, ng, ev;
    int nwc[NC], ndc[NC];
    logic [15:0] ebase[NC];
    logic [15:0] v1_stall;
`ifdef FEEDER_STALL_CNT_EN
    v1_stall = 16'd5;
`else
    v1_stall = 16'd0;
`endif
    //         ch base   len flo fhi nlo nhi first    last     fl dl stall
    vt[0] = '{0, 8'h10, 6, 0, -1, 0, -1, 16'h0010, 16'h0015, 2, 8,  16'd0};
    vt[1] = '{1, 8'h20, 9, 3,  7, 4,  8, 16'h0020, 16'h0028, 2, 16, v1_stall};
    vt[2] = '{2, 8'hFE, 4, 0, -1, 0, -1, 16'h00FE, 16'h0001, 2, 6,  16'd0};
    vt[3] = '{0, 8'h55, 0, 0, -1, 0, -1, 16'h0000, 16'h0000, -1, 1, 16'd0};
    vt[4] = '{1, 8'h80, 1, 0, -1, 0, -1, 16'h0080, 16'h0080, 2, 3,  16'd0};

    rst = 1'b1; start = '0; pe_full = '0; base_addr = '0; burst_len = '0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_rd_addr", 32'(mem_rd_addr), 0);
    chk("rst_out_en", 32'(out_en), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_stall", 32'(stall_cnt[31:0]), 0);
    do_reset();

    for (int i = 0; i < 5; i++) run_vec(vt[i]);

    // All three channels started together: grants must rotate 0,1,2,...
    do_reset();
    ebase[0] = 16'h0000; ebase[1] = 16'h0040; ebase[2] = 16'h0080;
    ng = 0;
    for (int c = 0; c < NC; c++) begin nwc[c] = 0; ndc[c] = 0; end
    @(posedge clk); #1;
    start = 3'b111;
    base_addr = {8'h80, 8'h40, 8'h00};
    burst_len = {8'd4, 8'd4, 8'd4};
    for (int k = 0; k < 30; k++) begin
      if (k > 0) begin @(posedge clk); #1; start = '0; end
      @(negedge clk);
      if (mem_rd_en) begin
        chk("rr_grant", 32'(mem_rd_addr[7:6]), ng % 3);
        ng++;
      end
      for (int c = 0; c < NC; c++) begin
        if (out_en[c]) begin
          chk("multi_word", 32'(out_data[c*DW +: DW]), 32'(ebase[c]) + nwc[c]);
          nwc[c]++;
        end
        if (done[c]) ndc[c]++;
      end
    end
    chk("multi_grants", ng, 12);
    for (int c = 0; c < NC; c++) begin
      chk("multi_words", nwc[c], 4);
      chk("multi_done", ndc[c], 1);
    end

    // Reset mid-burst after 3 of 8 words, then a full rerun.
    do_reset();
    @(posedge clk); #1;
    start = 3'b001; base_addr[AW-1:0] = 8'h30; burst_len[LW-1:0] = 8'd8;
    nw = 0;
    for (int k = 0; k < 20 && nw < 3; k++) begin
      if (k > 0) begin @(posedge clk); #1; start = '0; end
      @(negedge clk);
      if (out_en[0]) begin
        chk("pre_rst_word", 32'(out_data[DW-1:0]), 32'h30 + nw);
        nw++;
      end
    end
    chk("pre_rst_count", nw, 3);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_rd_en", 32'(mem_rd_en), 0);
    chk("midrst_rd_addr", 32'(mem_rd_addr), 0);
    chk("midrst_out_en", 32'(out_en), 0);
    chk("midrst_out_data", 32'(out_data), 0);
    @(posedge clk); #1 rst = 1'b0;
    ev = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if ((done | out_en | busy) != '0 || mem_rd_en) ev++;
      @(posedge clk); #1;
    end
    chk("post_rst_quiet", ev, 0);
    start = 3'b001;
    nw = 0; nd = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin @(posedge clk); #1; start = '0; end
      @(negedge clk);
      if (out_en[0]) begin
        chk("rerun_word", 32'(out_data[DW-1:0]), 32'h30 + nw);
        nw++;
      end
      if (done[0]) nd++;
    end
    chk("rerun_count", nw, 8);
    chk("rerun_done", nd, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
